// File: rtl/mem_flash_pkg.sv
// Opcodes, state encoding and helpers shared by the flash transaction sequencer.
package mem_flash_pkg;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_QREAD = 8'h6B;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_QPP   = 8'h32;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    localparam int WIP_BIT = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_GAP,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_RD_DATA,
        S_WR_DATA,
        S_POLL_CMD,
        S_POLL_RD,
        S_DONE
    } state_t;

    function automatic logic [7:0] cmd_opcode(input logic wr, input logic quad);
        if (wr) return quad ? OP_QPP : OP_PP;
        return quad ? OP_QREAD : OP_READ;
    endfunction

endpackage

// File: rtl/mem_txn_fsm.sv
// Sequences one read or page-program request into byte-level flash commands
// over the SPI controller's start/done, tx and rx handshakes.
module mem_txn_fsm
    import mem_flash_pkg::*;
#(
    parameter int unsigned CS_GAP   = 4,
    parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        qed,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        resp_valid,
    output logic        resp_err,
    output logic        spi_start,
    output logic        spi_r_w,
    output logic        spi_quad,
    input  logic        spi_done,
    output logic        spi_tx_valid,
    input  logic        spi_tx_ready,
    output logic [7:0]  spi_tx_data,
    input  logic        spi_rx_valid,
    output logic        spi_rx_ready,
    input  logic [7:0]  spi_rx_data,
    output state_t      dbg_state
);

    localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

    state_t      state_q, next_q;
    logic        wait_done_q;
    logic [23:0] addr_q;
    logic [8:0]  cnt_q;
    logic [1:0]  idx_q;
    logic [15:0] poll_q;
    logic [7:0]  gap_q;
    logic        wr_q, qed_q, wip_q;
    logic        req_ready_q, resp_valid_q, resp_err_q;
    logic        spi_start_q, spi_r_w_q, spi_quad_q, spi_tx_valid_q;
    logic [7:0]  spi_tx_data_q;

    logic        tx_hs, byte_done, wip_now, wr_ready_w;
    logic [8:0]  page_end;

    // Every stream transfers on a cycle where valid && ready are both high;
    // a tx byte counts as finished only on the spi_done that follows it.
    assign tx_hs      = spi_tx_valid_q && spi_tx_ready;
    assign byte_done  = wait_done_q && spi_done;
    assign wip_now    = spi_rx_valid ? spi_rx_data[WIP_BIT] : wip_q;
    assign page_end   = {1'b0, req_addr[7:0]} + {1'b0, req_len};
    assign wr_ready_w = (state_q == S_WR_DATA) && !spi_tx_valid_q && !wait_done_q;

    assign wr_ready     = wr_ready_w;
    assign rd_valid     = (state_q == S_RD_DATA) && spi_rx_valid;
    assign rd_data      = (state_q == S_RD_DATA) ? spi_rx_data : 8'h00;
    assign spi_rx_ready = (state_q == S_RD_DATA) ? rd_ready : (state_q == S_POLL_RD);

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign spi_start    = spi_start_q;
    assign spi_r_w      = spi_r_w_q;
    assign spi_quad     = spi_quad_q;
    assign spi_tx_valid = spi_tx_valid_q;
    assign spi_tx_data  = spi_tx_data_q;
    assign dbg_state    = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            next_q         <= S_IDLE;
            wait_done_q    <= 1'b0;
            addr_q         <= '0;
            cnt_q          <= '0;
            idx_q          <= '0;
            poll_q         <= '0;
            gap_q          <= '0;
            wr_q           <= 1'b0;
            qed_q          <= 1'b0;
            wip_q          <= 1'b0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            spi_start_q    <= 1'b0;
            spi_r_w_q      <= 1'b0;
            spi_quad_q     <= 1'b0;
            spi_tx_valid_q <= 1'b0;
            spi_tx_data_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            if (tx_hs) begin
                spi_tx_valid_q <= 1'b0;
                wait_done_q    <= 1'b1;
            end
            if (byte_done) wait_done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        wr_q        <= req_wr;
                        qed_q       <= qed;
                        cnt_q       <= {1'b0, req_len} + 9'd1;
                        poll_q      <= '0;
                        if (req_wr && page_end[8]) begin
                            state_q      <= S_DONE;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q        <= req_wr ? S_WREN : S_CMD;
                            spi_start_q    <= 1'b1;
                            spi_tx_valid_q <= 1'b1;
                            spi_tx_data_q  <= req_wr ? OP_WREN : cmd_opcode(1'b0, qed);
                        end
                    end
                end
                S_WREN: begin
                    if (byte_done) begin
                        spi_start_q <= 1'b0;
                        gap_q       <= GAP_LOAD;
                        next_q      <= S_CMD;
                        state_q     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == 8'd0) begin
                        spi_start_q    <= 1'b1;
                        spi_tx_valid_q <= 1'b1;
                        spi_tx_data_q  <= (next_q == S_POLL_CMD) ? OP_RDSR : cmd_opcode(wr_q, qed_q);
                        state_q        <= next_q;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                S_CMD: begin
                    if (byte_done) begin
                        idx_q          <= 2'd0;
                        spi_tx_valid_q <= 1'b1;
                        spi_tx_data_q  <= addr_q[23:16];
                        state_q        <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (byte_done) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd0) begin
                            spi_tx_valid_q <= 1'b1;
                            spi_tx_data_q  <= addr_q[15:8];
                        end else if (idx_q == 2'd1) begin
                            spi_tx_valid_q <= 1'b1;
                            spi_tx_data_q  <= addr_q[7:0];
                        end else if (wr_q) begin
                            spi_quad_q <= qed_q;
                            state_q    <= S_WR_DATA;
                        end else if (qed_q) begin
                            spi_tx_valid_q <= 1'b1;
                            spi_tx_data_q  <= 8'h00;
                            state_q        <= S_DUMMY;
                        end else begin
                            spi_r_w_q <= 1'b1;
                            state_q   <= S_RD_DATA;
                        end
                    end
                end
                S_DUMMY: begin
                    if (byte_done) begin
                        spi_r_w_q  <= 1'b1;
                        spi_quad_q <= qed_q;
                        state_q    <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (spi_done) begin
                        cnt_q <= cnt_q - 9'd1;
                        if (cnt_q == 9'd1) begin
                            spi_start_q  <= 1'b0;
                            spi_r_w_q    <= 1'b0;
                            spi_quad_q   <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            state_q      <= S_DONE;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (wr_valid && wr_ready_w) begin
                        spi_tx_valid_q <= 1'b1;
                        spi_tx_data_q  <= wr_data;
                    end
                    if (byte_done) begin
                        cnt_q <= cnt_q - 9'd1;
                        if (cnt_q == 9'd1) begin
                            spi_start_q <= 1'b0;
                            spi_quad_q  <= 1'b0;
                            gap_q       <= GAP_LOAD;
                            next_q      <= S_POLL_CMD;
                            state_q     <= S_GAP;
                        end
                    end
                end
                S_POLL_CMD: begin
                    if (byte_done) begin
                        spi_r_w_q <= 1'b1;
                        state_q   <= S_POLL_RD;
                    end
                end
                S_POLL_RD: begin
                    if (spi_rx_valid) wip_q <= spi_rx_data[WIP_BIT];
                    if (spi_done) begin
                        spi_start_q <= 1'b0;
                        spi_r_w_q   <= 1'b0;
                        poll_q      <= poll_q + 16'd1;
                        if (!wip_now) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            state_q      <= S_DONE;
                        end else if (poll_q + 16'd1 == POLL_MAX) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            gap_q   <= GAP_LOAD;
                            next_q  <= S_POLL_CMD;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_DONE: begin
                    resp_err_q  <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_txn_fsm.sv
// Directed bench for mem_txn_fsm with a small byte-level SPI controller model.
module tb_mem_txn_fsm;
    import mem_flash_pkg::*;

    localparam int unsigned CS_GAP   = 4;
    localparam logic [15:0] POLL_MAX = 16'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        qed, req_valid, req_ready, req_wr;
    logic [23:0] req_addr;
    logic [7:0]  req_len;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid, rd_ready;
    logic [7:0]  rd_data;
    logic        resp_valid, resp_err;
    logic        spi_start, spi_r_w, spi_quad, spi_done;
    logic        spi_tx_valid, spi_tx_ready;
    logic [7:0]  spi_tx_data;
    logic        spi_rx_valid, spi_rx_ready;
    logic [7:0]  spi_rx_data;
    state_t      dbg_state;

    mem_txn_fsm #(.CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .rst(rst), .qed(qed),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .spi_start(spi_start), .spi_r_w(spi_r_w), .spi_quad(spi_quad), .spi_done(spi_done),
        .spi_tx_valid(spi_tx_valid), .spi_tx_ready(spi_tx_ready), .spi_tx_data(spi_tx_data),
        .spi_rx_valid(spi_rx_valid), .spi_rx_ready(spi_rx_ready), .spi_rx_data(spi_rx_data),
        .dbg_state(dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    logic [7:0] tx_log[$], rx_src[$], rd_log[$], wr_src[$];
    logic       txq_log[$], rxq_log[$];
    int         done_dly, cmd_cnt, low_run, min_gap, resp_cnt, rw_bad;
    logic       last_err, start_prev, wr_taken, pend;
    int         pass_cnt = 0;
    int         check_cnt = 0;

    // SPI controller model: one byte at a time, spi_done a few cycles after each byte.
    always @(posedge clk) begin
        spi_done <= 1'b0;
        if (rst) begin
            done_dly = 0;
            spi_rx_valid <= 1'b0;
            spi_rx_data  <= 8'h00;
        end else begin
            pend = (done_dly != 0);
            if (done_dly == 1) spi_done <= 1'b1;
            if (done_dly != 0) done_dly = done_dly - 1;
            if (spi_tx_valid && spi_tx_ready) begin
                tx_log.push_back(spi_tx_data);
                txq_log.push_back(spi_quad);
                if (spi_r_w) rw_bad++;
                done_dly = 2;
            end
            if (spi_rx_valid && spi_rx_ready) begin
                rxq_log.push_back(spi_quad);
                if (!spi_r_w) rw_bad++;
                spi_rx_valid <= 1'b0;
                done_dly = 1;
            end else if (!spi_rx_valid && !spi_done && !pend && spi_start && spi_r_w
                         && rx_src.size() > 0) begin
                spi_rx_valid <= 1'b1;
                spi_rx_data  <= rx_src.pop_front();
            end
        end
    end

    // Stream, response and chip-select monitor.
    always @(posedge clk) begin
        if (!rst) begin
            if (rd_valid && rd_ready) rd_log.push_back(rd_data);
            if (wr_valid && wr_ready) wr_taken = 1'b1;
            if (resp_valid) begin
                resp_cnt++;
                last_err = resp_err;
            end
            if (spi_start && !start_prev) begin
                if (cmd_cnt > 0 && low_run < min_gap) min_gap = low_run;
                cmd_cnt++;
            end
            low_run = spi_start ? 0 : low_run + 1;
        end
        start_prev = spi_start;
    end

    function automatic logic [127:0] pack_bytes(input logic [7:0] q[$]);
        logic [127:0] acc = '0;
        for (int k = 0; k < q.size(); k++) acc = (acc << 8) | {120'd0, q[k]};
        return acc;
    endfunction

    function automatic logic [15:0] pack_bits(input logic q[$]);
        logic [15:0] acc = '0;
        for (int k = 0; k < q.size(); k++) acc = (acc << 1) | {15'd0, q[k]};
        return acc;
    endfunction

    // driver tasks
    task automatic clear_logs();
        tx_log.delete(); rx_src.delete(); rd_log.delete(); wr_src.delete();
        txq_log.delete(); rxq_log.delete();
        cmd_cnt = 0; min_gap = 1000; resp_cnt = 0; rw_bad = 0; last_err = 1'b0;
        wr_taken = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic q, input logic [23:0] a, input logic [7:0] l);
        @(negedge clk);
        req_wr = wr; qed = q; req_addr = a; req_len = l; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input int max_cyc, input bit toggle, input int stop_rd, output bit ok);
        logic [7:0] tmp;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (wr_taken) begin
                tmp = wr_src.pop_front();
                wr_taken = 1'b0;
            end
            wr_valid     = (wr_src.size() > 0);
            wr_data      = wr_valid ? wr_src[0] : 8'h00;
            rd_ready     = toggle ? i[1] : 1'b1;
            spi_tx_ready = toggle ? (i % 3 != 2) : 1'b1;
            if (resp_cnt > 0 || (stop_rd > 0 && rd_log.size() >= stop_rd)) begin
                ok = 1'b1;
                break;
            end
        end
        wr_valid = 1'b0;
        spi_tx_ready = 1'b1;
        if (stop_rd == 0) repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else pass_cnt++;
        check_cnt++; if (spi_start !== 1'b0) $display("FAIL reset_spi_start: got %b want 0", spi_start); else pass_cnt++;
        check_cnt++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else pass_cnt++;
        check_cnt++; if (spi_tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", spi_tx_valid); else pass_cnt++;
        check_cnt++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", wr_ready); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_single();
        bit ok;
        clear_logs();
        rx_src = '{8'h11, 8'h22, 8'h33, 8'h44};
        issue(1'b0, 1'b0, 24'h012345, 8'h03);
        run_txn(400, 1'b0, 0, ok);
        check_cnt++; if (ok !== 1'b1) $display("FAIL rd1_timeout: no resp within budget"); else pass_cnt++;
        check_cnt++; if (tx_log.size() != 4) $display("FAIL rd1_tx_count: got %0d want 4", tx_log.size()); else pass_cnt++;
        check_cnt++; if (pack_bytes(tx_log) !== 128'h03012345) $display("FAIL rd1_tx_bytes: got %h want 03012345", pack_bytes(tx_log)); else pass_cnt++;
        check_cnt++; if (pack_bytes(rd_log) !== 128'h11223344 || rd_log.size() != 4) $display("FAIL rd1_rd_bytes: got %h want 11223344", pack_bytes(rd_log)); else pass_cnt++;
        check_cnt++; if ((pack_bits(txq_log) | pack_bits(rxq_log)) !== 16'h0) $display("FAIL rd1_quad: got %h want 0", pack_bits(rxq_log)); else pass_cnt++;
        check_cnt++; if (resp_cnt != 1 || last_err !== 1'b0) $display("FAIL rd1_resp: got cnt %0d err %b want 1/0", resp_cnt, last_err); else pass_cnt++;
        check_cnt++; if (cmd_cnt != 1 || rw_bad != 0) $display("FAIL rd1_cmds: got cmds %0d rw_bad %0d want 1/0", cmd_cnt, rw_bad); else pass_cnt++;
    endtask

    task automatic test_read_quad();
        bit ok;
        clear_logs();
        rx_src = '{8'hC3};
        issue(1'b0, 1'b1, 24'h000100, 8'h00);
        run_txn(400, 1'b0, 0, ok);
        check_cnt++; if (ok !== 1'b1) $display("FAIL rdq_timeout: no resp within budget"); else pass_cnt++;
        check_cnt++; if (tx_log.size() != 5 || pack_bytes(tx_log) !== 128'h6B00010000) $display("FAIL rdq_tx_bytes: got %h want 6b00010000", pack_bytes(tx_log)); else pass_cnt++;
        check_cnt++; if (pack_bits(txq_log) !== 16'h0) $display("FAIL rdq_tx_quad: got %h want 0", pack_bits(txq_log)); else pass_cnt++;
        check_cnt++; if (rxq_log.size() != 1 || pack_bits(rxq_log) !== 16'h1) $display("FAIL rdq_rx_quad: got %h want 1", pack_bits(rxq_log)); else pass_cnt++;
        check_cnt++; if (rd_log.size() != 1 || pack_bytes(rd_log) !== 128'hC3) $display("FAIL rdq_rd_bytes: got %h want c3", pack_bytes(rd_log)); else pass_cnt++;
        check_cnt++; if (resp_cnt != 1 || last_err !== 1'b0) $display("FAIL rdq_resp: got cnt %0d err %b want 1/0", resp_cnt, last_err); else pass_cnt++;
    endtask

    task automatic test_write();
        bit ok;
        clear_logs();
        wr_src = '{8'hAA, 8'h55};
        rx_src = '{8'h03, 8'h00};
        issue(1'b1, 1'b0, 24'h000010, 8'h01);
        run_txn(600, 1'b0, 0, ok);
        check_cnt++; if (ok !== 1'b1) $display("FAIL wr_timeout: no resp within budget"); else pass_cnt++;
        check_cnt++; if (tx_log.size() != 9 || pack_bytes(tx_log) !== 128'h060200001_0AA550505) $display("FAIL wr_tx_bytes: got %h want 06020000 10aa550505", pack_bytes(tx_log)); else pass_cnt++;
        check_cnt++; if (cmd_cnt != 4) $display("FAIL wr_cmds: got %0d want 4", cmd_cnt); else pass_cnt++;
        check_cnt++; if (min_gap < CS_GAP) $display("FAIL wr_cs_gap: got %0d want >= %0d", min_gap, CS_GAP); else pass_cnt++;
        check_cnt++; if (pack_bits(txq_log) !== 16'h0 || rw_bad != 0) $display("FAIL wr_phase: got quad %h rw_bad %0d want 0/0", pack_bits(txq_log), rw_bad); else pass_cnt++;
        check_cnt++; if (wr_src.size() != 0 || rx_src.size() != 0) $display("FAIL wr_consumed: got wr %0d rx %0d left want 0/0", wr_src.size(), rx_src.size()); else pass_cnt++;
        check_cnt++; if (resp_cnt != 1 || last_err !== 1'b0) $display("FAIL wr_resp: got cnt %0d err %b want 1/0", resp_cnt, last_err); else pass_cnt++;
    endtask

    task automatic test_page_cross();
        clear_logs();
        @(negedge clk);
        req_wr = 1'b1; qed = 1'b0; req_addr = 24'h0000F0; req_len = 8'h1F; req_valid = 1'b1;
        @(posedge clk);
        #1;
        check_cnt++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) $display("FAIL pgx_resp_timing: got valid %b err %b want 1/1", resp_valid, resp_err); else pass_cnt++;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check_cnt++; if (cmd_cnt != 0 || tx_log.size() != 0) $display("FAIL pgx_no_flash: got cmds %0d bytes %0d want 0/0", cmd_cnt, tx_log.size()); else pass_cnt++;
        check_cnt++; if (resp_cnt != 1 || req_ready !== 1'b1) $display("FAIL pgx_single_resp: got cnt %0d ready %b want 1/1", resp_cnt, req_ready); else pass_cnt++;
    endtask

    task automatic test_poll_timeout();
        bit ok;
        clear_logs();
        wr_src = '{8'h5A};
        rx_src = '{8'h01, 8'h01, 8'h01, 8'h01};
        issue(1'b1, 1'b1, 24'h000000, 8'h00);
        run_txn(800, 1'b1, 0, ok);
        check_cnt++; if (ok !== 1'b1) $display("FAIL to_timeout: no resp within budget"); else pass_cnt++;
        check_cnt++; if (tx_log.size() != 9 || pack_bytes(tx_log) !== 128'h063200000_05A050505) $display("FAIL to_tx_bytes: got %h want 0632000000 5a050505", pack_bytes(tx_log)); else pass_cnt++;
        check_cnt++; if (pack_bits(txq_log) !== 16'h0008) $display("FAIL to_tx_quad: got %h want 0008", pack_bits(txq_log)); else pass_cnt++;
        check_cnt++; if (rx_src.size() != 1 || cmd_cnt != 5) $display("FAIL to_poll_count: got rx left %0d cmds %0d want 1/5", rx_src.size(), cmd_cnt); else pass_cnt++;
        check_cnt++; if (resp_cnt != 1 || last_err !== 1'b1) $display("FAIL to_resp: got cnt %0d err %b want 1/1", resp_cnt, last_err); else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        clear_logs();
        rx_src = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
        issue(1'b0, 1'b0, 24'h000000, 8'h07);
        run_txn(800, 1'b1, 4, ok);
        check_cnt++; if (ok !== 1'b1) $display("FAIL rst_mid_progress: got %0d bytes want 4", rd_log.size()); else pass_cnt++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_cnt++; if (spi_start !== 1'b0) $display("FAIL rst_mid_spi_start: got %b want 0", spi_start); else pass_cnt++;
        check_cnt++; if (req_ready !== 1'b1 || dbg_state !== S_IDLE) $display("FAIL rst_mid_idle: got ready %b state %0d want 1/0", req_ready, dbg_state); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        rd_ready = 1'b1;
        repeat (8) @(negedge clk);
        check_cnt++; if (resp_cnt != 0) $display("FAIL rst_mid_no_resp: got %0d want 0", resp_cnt); else pass_cnt++;
        check_cnt++; if (rd_log.size() != 4 || pack_bytes(rd_log) !== 128'h80818283) $display("FAIL rst_mid_rd_bytes: got %h want 80818283", pack_bytes(rd_log)); else pass_cnt++;
        rx_src.delete();
    endtask

    initial begin
        rst = 1'b1; qed = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1; spi_tx_ready = 1'b1;
        done_dly = 0; low_run = 0; start_prev = 1'b0; pend = 1'b0;
        clear_logs();
        test_reset();
        test_read_single();
        test_read_quad();
        test_write();
        test_page_cross();
        test_poll_timeout();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
